// File: rtl/lx_mem_pkg.sv
// Message and state encodings shared by the Lx memory interface and its bench.
package lx_mem_pkg;

    localparam logic [3:0] NO_REQ     = 4'd0;
    localparam logic [3:0] R_REQ      = 4'd1;
    localparam logic [3:0] WB_REQ     = 4'd2;

    localparam logic [3:0] MEM_NO_MSG = 4'd0;
    localparam logic [3:0] MEM_READY  = 4'd1;
    localparam logic [3:0] MEM_C_WB   = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/lx_memory_interface.sv
// Line-to-word bridge: splits cache line requests into word beats on main memory
// and reassembles read returns into a line, one line transaction at a time.
//
// Beat handshake: a beat (mem_read or mem_write with mem_address/mem_wdata) is
// transferred on a rising edge where it is presented and mem_ready is high; until
// then every beat output holds. Read data returns on mem_rvalid in issue order,
// with no back-pressure from this block.
module lx_memory_interface
    import lx_mem_pkg::*;
#(
    parameter  int CACHE_OFFSET_BITS = 2,
    parameter  int DATA_WIDTH        = 32,
    parameter  int ADDRESS_BITS      = 32,
    parameter  int MSG_BITS          = 4,
    localparam int CACHE_WORDS       = 1 << CACHE_OFFSET_BITS,
    localparam int CACHE_WIDTH       = DATA_WIDTH * CACHE_WORDS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [MSG_BITS-1:0]     cache2mem_msg,
    input  logic [ADDRESS_BITS-1:0] cache2mem_address,
    input  logic [CACHE_WIDTH-1:0]  cache2mem_data,
    output logic [MSG_BITS-1:0]     mem2cache_msg,
    output logic [ADDRESS_BITS-1:0] mem2cache_address,
    output logic [CACHE_WIDTH-1:0]  mem2cache_data,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_rvalid,
    output state_t                  o_dbg_state
);

    localparam int             CW      = CACHE_OFFSET_BITS + 1;
    localparam logic [CW-1:0]  LAST    = CW'(CACHE_WORDS - 1);
    localparam logic [CW-1:0]  WORDS_C = CW'(CACHE_WORDS);

    state_t                  r_state;
    state_t                  w_state_n;
    logic [CW-1:0]           r_issue_cnt,   w_issue_n;
    logic [CW-1:0]           r_recv_cnt,    w_recv_n;
    logic [ADDRESS_BITS-1:0] r_line_addr,   w_line_addr_n;
    logic [CACHE_WIDTH-1:0]  r_line,        w_line_n;
    logic [MSG_BITS-1:0]     r_resp_msg,    w_resp_msg_n;
    logic [ADDRESS_BITS-1:0] r_resp_addr,   w_resp_addr_n;
    logic [CACHE_WIDTH-1:0]  r_resp_data,   w_resp_data_n;
    logic                    r_mem_read,    w_mem_read_n;
    logic                    r_mem_write,   w_mem_write_n;
    logic [ADDRESS_BITS-1:0] r_mem_address, w_mem_address_n;
    logic [DATA_WIDTH-1:0]   r_mem_wdata,   w_mem_wdata_n;

    logic                    w_req_rd, w_req_wb, w_req_none;
    logic [ADDRESS_BITS-1:0] w_req_aligned;
    logic                    w_issue_fire, w_issue_last, w_recv_fire, w_recv_last;
    logic [CW-1:0]           w_issue_inc;

    assign w_req_rd      = (cache2mem_msg == MSG_BITS'(R_REQ));
    assign w_req_wb      = (cache2mem_msg == MSG_BITS'(WB_REQ));
    assign w_req_none    = (cache2mem_msg == MSG_BITS'(NO_REQ));
    assign w_req_aligned = cache2mem_address & ~ADDRESS_BITS'(CACHE_WORDS - 1);

    assign w_issue_fire  = (r_mem_read | r_mem_write) & mem_ready;
    assign w_issue_last  = (r_issue_cnt == LAST);
    assign w_issue_inc   = r_issue_cnt + 1'b1;
    assign w_recv_fire   = (r_state == ST_READ) & mem_rvalid & (r_recv_cnt < WORDS_C);
    assign w_recv_last   = (r_recv_cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE:  if (w_req_rd)                      w_state_n = ST_READ;
                      else if (w_req_wb)                 w_state_n = ST_WRITE;
            ST_WRITE: if (w_issue_fire && w_issue_last)  w_state_n = ST_RESP;
            ST_READ:  if (w_recv_fire && w_recv_last)    w_state_n = ST_RESP;
            ST_RESP:  if (w_req_none)                    w_state_n = ST_IDLE;
            default:                                     w_state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue_n       = r_issue_cnt;
        w_recv_n        = r_recv_cnt;
        w_line_addr_n   = r_line_addr;
        w_line_n        = r_line;
        w_resp_msg_n    = r_resp_msg;
        w_resp_addr_n   = r_resp_addr;
        w_resp_data_n   = r_resp_data;
        w_mem_read_n    = r_mem_read;
        w_mem_write_n   = r_mem_write;
        w_mem_address_n = r_mem_address;
        w_mem_wdata_n   = r_mem_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_req_rd || w_req_wb) begin
                    w_line_addr_n   = w_req_aligned;
                    w_issue_n       = '0;
                    w_recv_n        = '0;
                    w_mem_address_n = w_req_aligned;
                    w_mem_read_n    = w_req_rd;
                    w_mem_write_n   = w_req_wb;
                    if (w_req_wb) begin
                        w_line_n      = cache2mem_data;
                        w_mem_wdata_n = cache2mem_data[DATA_WIDTH-1:0];
                    end
                end
            end
            ST_WRITE: begin
                if (w_issue_fire) begin
                    w_issue_n = w_issue_inc;
                    if (w_issue_last) begin
                        w_mem_write_n = 1'b0;
                        w_resp_msg_n  = MSG_BITS'(MEM_C_WB);
                        w_resp_addr_n = r_line_addr;
                        w_resp_data_n = '0;
                    end else begin
                        w_mem_address_n = r_line_addr + ADDRESS_BITS'(w_issue_inc);
                        w_mem_wdata_n   = r_line[int'(w_issue_inc)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            ST_READ: begin
                // Issue and receive advance independently; returns may overlap later issues.
                if (w_issue_fire) begin
                    w_issue_n = w_issue_inc;
                    if (w_issue_last) begin
                        w_mem_read_n = 1'b0;
                    end else begin
                        w_mem_address_n = r_line_addr + ADDRESS_BITS'(w_issue_inc);
                    end
                end
                if (w_recv_fire) begin
                    w_line_n[int'(r_recv_cnt)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                    w_recv_n = r_recv_cnt + 1'b1;
                    if (w_recv_last) begin
                        w_mem_read_n  = 1'b0;
                        w_resp_msg_n  = MSG_BITS'(MEM_READY);
                        w_resp_addr_n = r_line_addr;
                        w_resp_data_n = w_line_n;
                    end
                end
            end
            ST_RESP: begin
                if (w_req_none) begin
                    w_resp_msg_n    = MSG_BITS'(MEM_NO_MSG);
                    w_resp_addr_n   = '0;
                    w_resp_data_n   = '0;
                    w_mem_address_n = '0;
                    w_mem_wdata_n   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_issue_cnt   <= '0;
            r_recv_cnt    <= '0;
            r_line_addr   <= '0;
            r_line        <= '0;
            r_resp_msg    <= MSG_BITS'(MEM_NO_MSG);
            r_resp_addr   <= '0;
            r_resp_data   <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_issue_cnt   <= w_issue_n;
            r_recv_cnt    <= w_recv_n;
            r_line_addr   <= w_line_addr_n;
            r_line        <= w_line_n;
            r_resp_msg    <= w_resp_msg_n;
            r_resp_addr   <= w_resp_addr_n;
            r_resp_data   <= w_resp_data_n;
            r_mem_read    <= w_mem_read_n;
            r_mem_write   <= w_mem_write_n;
            r_mem_address <= w_mem_address_n;
            r_mem_wdata   <= w_mem_wdata_n;
        end
    end

    assign mem2cache_msg     = r_resp_msg;
    assign mem2cache_address = r_resp_addr;
    assign mem2cache_data    = r_resp_data;
    assign mem_read          = r_mem_read;
    assign mem_write         = r_mem_write;
    assign mem_address       = r_mem_address;
    assign mem_wdata         = r_mem_wdata;
    assign o_dbg_state       = r_state;

endmodule
